// File: rtl/iir_coeff_loader.sv
// Coefficient load sequencer for the cascaded-SOS IIR filter.
// Streams coefficient words into the filter's c_we/c_in/c_addr port, full or windowed reload.
module iir_coeff_loader #(
    parameter int ORD      = 10,
    parameter int COEFF_WH = 2,
    parameter int COEFF_FR = 14,
    parameter int TMO      = 1023,
    localparam int N  = ORD * 2,
    localparam int AW = $clog2(ORD * 2),
    localparam int CW = COEFF_WH + COEFF_FR
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] len,
    input  logic          s_valid,
    input  logic [CW-1:0] s_data,
    output logic          s_ready,
    output logic          c_we,
    output logic [CW-1:0] c_in,
    output logic [AW-1:0] c_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // state | meaning
    // IDLE  | waiting for start
    // CHECK | range check of latched base/length
    // LOAD  | accepting words, one write per handshake
    // FIN   | done pulse, back to IDLE next cycle

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, CHECK, LOAD, FIN} state_t;

    state_t        state;
    logic [AW:0]   base;
    logic [AW:0]   length;
    logic [AW:0]   idx;
    logic [TW-1:0] tmo_cnt;
    logic [AW+1:0] span_end;
    logic [AW:0]   idx_next;
    logic          hs;

    // one extra bit beyond the sum so an out-of-range window can never wrap
    assign span_end = {1'b0, base} + {1'b0, length};
    assign idx_next = idx + (AW+1)'(1);
    assign hs       = s_valid && s_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            base    <= '0;
            length  <= '0;
            idx     <= '0;
            tmo_cnt <= '0;
            s_ready <= 1'b0;
            c_we    <= 1'b0;
            c_in    <= '0;
            c_addr  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            c_we <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CHECK;
                        if (len == '0) begin
                            base   <= '0;
                            length <= (AW+1)'(N);
                        end else begin
                            base   <= {1'b0, start_addr};
                            length <= {1'b0, len};
                        end
                    end
                end
                CHECK: begin
                    if (span_end > (AW+2)'(N)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx     <= '0;
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        c_we    <= 1'b1;
                        c_in    <= s_data;
                        c_addr  <= AW'(base + idx);
                        idx     <= idx_next;
                        tmo_cnt <= '0;
                        if (idx_next == length) begin
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            state   <= FIN;
                        end
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        // abort: words already written stay written, no done
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        s_ready <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: expected writes queued at stimulus, checked by a monitor.
module tb_iir_coeff_loader;

    localparam int ORD = 10;
    localparam int TMO = 8;
    localparam int AW  = 5;
    localparam int CW  = 16;

    logic          clk;
    logic          nrst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] len;
    logic          s_valid;
    logic [CW-1:0] s_data;
    logic          s_ready;
    logic          c_we;
    logic [CW-1:0] c_in;
    logic [AW-1:0] c_addr;
    logic          busy;
    logic          done;
    logic          err;

    iir_coeff_loader #(.ORD(ORD), .COEFF_WH(2), .COEFF_FR(14), .TMO(TMO)) dut (
        .clk(clk), .nrst(nrst), .start(start), .start_addr(start_addr), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .c_we(c_we), .c_in(c_in), .c_addr(c_addr),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (c_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(c_addr), 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("we_addr", 32'(c_addr), 32'(e.addr));
                    check("we_data", 32'(c_in), 32'(e.data));
                    check("we_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_last_we", 32'(c_we), 32'd1);
                check("done_err_exclusive", 32'(err), 32'd0);
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        len        = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("check_busy", 32'(busy), 32'd1);
        check("check_ready_low", 32'(s_ready), 32'd0);
    endtask

    // returns the cycle in which the handshake happened, -1 if it never came
    task automatic push_word(input logic [CW-1:0] d, input logic [AW-1:0] addr, output int acc_cyc);
        exp_t e;
        bit   ok;
        s_valid = 1'b1;
        s_data  = d;
        ok      = 1'b0;
        acc_cyc = -1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", 32'(s_ready), 32'd1);
        end else begin
            e.addr  = addr;
            e.data  = d;
            e.cyc   = cyc + 1;
            acc_cyc = cyc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_check();
        s_valid = 1'b0;
        @(negedge clk);
        check("fin_done", 32'(done), 32'd1);
        check("fin_ready_low", 32'(s_ready), 32'd0);
        check("fin_err", 32'(err), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    task automatic full_load(input logic [CW-1:0] base_data);
        int c;
        do_start('0, '0);
        for (int i = 0; i < 20; i++) push_word(base_data + CW'(i), AW'(i), c);
        finish_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_c_we"}, 32'(c_we), 32'd0);
        check({tag, "_c_in"}, 32'(c_in), 32'd0);
        check({tag, "_c_addr"}, 32'(c_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int acc;
        int d0;
        bit seen;
        nrst       = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        #22;
        check_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;

        // full load, back-to-back words
        full_load(16'h1000);

        // partial window with gaps on s_valid
        do_start(5'd8, 5'd4);
        for (int i = 0; i < 4; i++) begin
            push_word(16'h2200 + 16'(i), AW'(8 + i), c);
            if (i != 3) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        finish_check();

        // range error with s_valid held high throughout
        s_valid = 1'b1;
        s_data  = 16'hdead;
        do_start(5'd18, 5'd4);
        @(negedge clk);
        check("range_err", 32'(err), 32'd1);
        check("range_busy", 32'(busy), 32'd0);
        check("range_ready", 32'(s_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("range_err_sticky", 32'(err), 32'd1);
        s_valid = 1'b0;

        // boundary window ending exactly at N clears err
        do_start(5'd19, 5'd1);
        check("err_cleared", 32'(err), 32'd0);
        push_word(16'h0abc, 5'd19, c);
        finish_check();

        // timeout after one accepted word
        do_start(5'd5, 5'd3);
        push_word(16'h3333, 5'd5, acc);
        s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        check("tmo_err_seen", 32'(seen), 32'd1);
        check("tmo_err_cycle", 32'(cyc), 32'(acc + TMO + 1));
        check("tmo_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-load
        do_start('0, '0);
        for (int i = 0; i < 5; i++) push_word(16'h4000 + 16'(i), AW'(i), c);
        s_valid = 1'b0;
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        #2;
        nrst = 1'b1;
        @(negedge clk);
        check_all_zero("postrst");
        full_load(16'h5000);

        // start pulse while busy is ignored
        d0 = done_cnt;
        do_start('0, '0);
        for (int i = 0; i < 20; i++) begin
            push_word(16'h6000 + 16'(i), AW'(i), c);
            if (i == 4) begin
                start      = 1'b1;
                start_addr = 5'd2;
                len        = 5'd1;
            end
            if (i == 6) start = 1'b0;
        end
        finish_check();
        repeat (3) @(negedge clk);
        check("busy_start_single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Coefficient load sequencer for the cascaded-SOS IIR filter. It accepts coefficient words over a valid/ready stream and drives the filter's `c_we`/`c_in`/`c_addr` port with one write pulse per accepted word. It supports a full reload of all `ORD*2` coefficients or a partial reload of a contiguous address window. It sits between the host/config interface and the `iir` top, and is the only master of the filter's coefficient port.

## Interface
- `ORD`, 10, filter order; coefficient count `N = ORD*2` (4 per SOS).
- `COEFF_WH`, 2, coefficient integer bits.
- `COEFF_FR`, 14, coefficient fraction bits; `CW = COEFF_WH+COEFF_FR`.
- `TMO`, 1023, max idle cycles waiting for `s_valid` during a load before abort.
- `AW` (local) = `$clog2(ORD*2)`.

Ports:
- `clk`  in  1  single clock for the block.
- `nrst`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle load request; sampled only in IDLE.
- `start_addr`  in  AW  first coefficient address; sampled with `start`.
- `len`  in  AW  words to load; 0 means full load (`N` words from address 0, `start_addr` ignored).
- `s_valid`  in  1  coefficient word valid.
- `s_data`  in  CW  coefficient word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `c_we`  out  1  filter coefficient write strobe, one cycle per word.
- `c_in`  out  CW  coefficient to write.
- `c_addr`  out  AW  coefficient address.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag; cleared by the next accepted `start`.

## Operation
- States: IDLE, CHECK, LOAD, FIN.
- IDLE:
  - `s_ready = 0`.
  - On `start`, latch the effective base and length, clear `err` and the timeout counter, and go to CHECK.
- CHECK (1 cycle):
  - If `base + length > N`, set `err` and return to IDLE with no writes.
  - Otherwise go to LOAD with the word index at 0.
- LOAD:
  - `s_ready = 1`.
  - On handshake (`s_valid && s_ready`), register `c_in <= s_data`, `c_addr <= base + index`, and `c_we <= 1` for the next cycle only; increment the index and clear the timeout counter.
  - On the handshake that completes the requested length, go to FIN; `s_ready` drops the following cycle.
  - Without a handshake, the timeout counter increments. When it reaches `TMO`, set `err` and return to IDLE. Words already written stay written; `done` is not pulsed.
- FIN (1 cycle): pulse `done`, then go to IDLE.
- `start` is ignored in every state except IDLE; latched parameters are unaffected.
- `c_in`/`c_addr` hold their last written values while `c_we = 0`.
- Address arithmetic uses AW+1 bits for the range check; addresses never wrap.
- Holding `s_valid` high in IDLE/CHECK/FIN is harmless: no accept, no write.

## Timing
- Reset values: `s_ready = 0`, `c_we = 0`, `c_in = 0`, `c_addr = 0`, `busy = 0`, `done = 0`, `err = 0`; state is IDLE.
- Reset is asynchronous and may occur at any point, including mid-load. All outputs return to reset values immediately and the partial load is abandoned.
- Cycle t: `start`. Cycle t+1: CHECK, `busy = 1`. Cycle t+2: LOAD, `s_ready = 1`, or IDLE with `err = 1` for a range error.
- Handshake at cycle k gives `c_we = 1` with matching `c_in`/`c_addr` at k+1. Throughput is 1 word/cycle; back-to-back `c_we` pulses are allowed.
- Last handshake at cycle k: `c_we` at k+1, `done` at k+1 (FIN), `busy = 0` and IDLE at k+2.
- Timeout: with the last accept or LOAD entry at cycle k and no handshake after it, `err` rises and `busy` falls at cycle k+TMO+1.
- `done` and `err` never assert in the same load.

## Test plan
- Full load: `start`, `len = 0`, 20 back-to-back words 0x1000..0x1013 -> 20 consecutive `c_we` pulses, `c_addr` 0..19, `c_in` matching; `done` the same cycle as the last `c_we`; `err = 0`.
- Partial load with gaps: `start_addr = 8`, `len = 4`, `s_valid` toggling 1-0-1-0 -> exactly 4 `c_we` pulses at addresses 8,9,10,11, each one cycle after its handshake; `s_ready` low after the 4th accept.
- Range error: `start_addr = 18`, `len = 4` -> `err = 1` two cycles after `start`; no `c_we`, `s_ready` never high, no `done`. A following valid `start` clears `err`.
- Timeout (`TMO = 8`): `len = 3`, send 1 word then stall -> one `c_we` at address `start_addr`, then `err = 1` and `busy = 0` 9 cycles after the accept.
- Reset mid-load: assert `nrst = 0` after 5 of 20 words -> all outputs zero at once; after release, a fresh full load completes normally from address 0.
- `start` while busy: pulse `start` with `start_addr = 2`, `len = 1` during a full load -> ignored; the full load finishes with addresses 0..19 and a single `done`.
